divisor_normalizer: RTL and testbench

//  Front-end stage of the divider datapath. Accepts a dividend/divisor pair over a valid/ready handshake.

---
 rtl/divisor_normalizer_pkg.sv | 14 +
 rtl/divisor_normalizer_clz.sv | 32 +++
 rtl/divisor_normalizer.sv | 102 ++++++++++
 tb/tb_divisor_normalizer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/divisor_normalizer_pkg.sv
// Shared constants for the divisor normalizer: operand widths and FSM state encoding.
package divisor_normalizer_pkg;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/divisor_normalizer_clz.sv
// Combinational leading-zero counter. The count is SHW bits wide, so an
// all-zero input wraps to 0; callers must detect a zero operand separately.
module count_leading_zeros #(
    parameter int WIDTH = divisor_normalizer_pkg::WIDTH,
    parameter int SHW   = divisor_normalizer_pkg::SHW
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [SHW-1:0]   o_count
);

    logic [SHW-1:0] w_count;
    logic           w_found;

    // Scan from the MSB down, counting zeros until the first set bit.
    always_comb begin
        w_count = '0;
        w_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!w_found) begin
                if (i_data[i]) begin
                    w_found = 1'b1;
                end else begin
                    w_count = w_count + SHW'(1);
                end
            end
        end
    end

    assign o_count = i_en ? w_count : '0;

endmodule

// File: rtl/divisor_normalizer.sv
// Divider front end: registers a dividend/divisor pair, counts the divisor's
// leading zeros, then shifts both left one bit per cycle until the divisor
// MSB is set. A zero divisor is flagged and passed through unshifted.
module divisor_normalizer #(
    parameter int WIDTH = divisor_normalizer_pkg::WIDTH,
    parameter int SHW   = divisor_normalizer_pkg::SHW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   norm_divisor,
    output logic [2*WIDTH-1:0] norm_dividend,
    output logic [SHW-1:0]     shamt,
    output logic               div_by_zero
);

    import divisor_normalizer_pkg::*;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_divisor;
    logic [2*WIDTH-1:0] r_dividend;
    logic [SHW-1:0]     r_shamt;
    logic [SHW-1:0]     r_cnt;
    logic               r_dbz;

    logic               w_clz_en;
    logic [SHW-1:0]     w_clz;

    assign w_clz_en = (r_state == ST_LOAD);

    count_leading_zeros #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_clz (
        .i_en    (w_clz_en),
        .i_data  (r_divisor),
        .o_count (w_clz)
    );

    // FSM, remaining-shift counter and the divisor/dividend shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_shamt    <= '0;
            r_cnt      <= '0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_divisor  <= divisor;
                        r_dividend <= {{WIDTH{1'b0}}, dividend};
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // The clz output wraps to 0 for a zero divisor; never trust it then.
                    if (r_divisor == '0) begin
                        r_dbz   <= 1'b1;
                        r_shamt <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_dbz   <= 1'b0;
                        r_shamt <= w_clz;
                        r_cnt   <= w_clz;
                        r_state <= (w_clz == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_divisor  <= r_divisor << 1;
                    r_dividend <= r_dividend << 1;
                    r_cnt      <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == ST_IDLE);
    assign out_valid     = (r_state == ST_DONE);
    assign norm_divisor  = r_divisor;
    assign norm_dividend = r_dividend;
    assign shamt         = r_shamt;
    assign div_by_zero   = r_dbz;

endmodule

// File: tb/tb_divisor_normalizer.sv
// Self-checking bench for divisor_normalizer with a behavioural model.
module tb_divisor_normalizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  dividend = '0;
    logic [7:0]  divisor = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  norm_divisor;
    logic [15:0] norm_dividend;
    logic [2:0]  shamt;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;
    int accepts = 0;

    divisor_normalizer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dividend      (dividend),
        .divisor       (divisor),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .norm_divisor  (norm_divisor),
        .norm_dividend (norm_dividend),
        .shamt         (shamt),
        .div_by_zero   (div_by_zero)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) accepts <= accepts + 1;
    end

    // Model: number of doublings needed to bring the divisor into [128,255].
    function automatic int ref_shamt(input int dvs);
        int n = 0;
        int v = dvs;
        if (v == 0) return 0;
        while (v < 128) begin
            v = v * 2;
            n++;
        end
        return n;
    endfunction

    // Present one operand pair, wait for out_valid; returns cycles from accept edge.
    task automatic issue_op(input logic [7:0] dvs, input logic [7:0] dvd, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        divisor = dvs;
        dividend = dvd;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        divisor = 8'($urandom);
        dividend = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (norm_divisor !== 8'h00) begin errors++; $display("FAIL reset_norm_divisor: got %h want 00", norm_divisor); end
        checks++; if (norm_dividend !== 16'h0000) begin errors++; $display("FAIL reset_norm_dividend: got %h want 0000", norm_dividend); end
        checks++; if (shamt !== 3'd0) begin errors++; $display("FAIL reset_shamt: got %0d want 0", shamt); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    // Directed corner vectors followed by random operands with random output stalls.
    task automatic test_normalize();
        logic [7:0] dvs_q[$];
        logic [7:0] dvd_q[$];
        int lat, n, stall;
        logic [7:0]  exp_nv;
        logic [15:0] exp_nd;
        dvs_q = '{8'h01, 8'h80, 8'h00};
        dvd_q = '{8'hFF, 8'h12, 8'h55};
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) dvs_q.push_back(8'h00);
            else dvs_q.push_back(8'(($urandom | 32'h80) & 32'hFF) >> $urandom_range(0, 7));
            dvd_q.push_back(8'($urandom));
        end
        foreach (dvs_q[i]) begin
            n = ref_shamt(int'(dvs_q[i]));
            exp_nv = 8'(int'(dvs_q[i]) * (1 << n));
            exp_nd = 16'(int'(dvd_q[i]) * (1 << n));
            issue_op(dvs_q[i], dvd_q[i], lat);
            checks++; if (lat != 1 + n) begin errors++; $display("FAIL latency[%0d] dvs=%h: got %0d want %0d", i, dvs_q[i], lat, 1 + n); end
            checks++; if (shamt !== 3'(n)) begin errors++; $display("FAIL shamt[%0d] dvs=%h: got %0d want %0d", i, dvs_q[i], shamt, n); end
            checks++; if (norm_divisor !== exp_nv) begin errors++; $display("FAIL norm_divisor[%0d] dvs=%h: got %h want %h", i, dvs_q[i], norm_divisor, exp_nv); end
            checks++; if (norm_dividend !== exp_nd) begin errors++; $display("FAIL norm_dividend[%0d] dvd=%h: got %h want %h", i, dvd_q[i], norm_dividend, exp_nd); end
            checks++; if (div_by_zero !== (dvs_q[i] == 8'h00)) begin errors++; $display("FAIL dbz[%0d] dvs=%h: got %b want %b", i, dvs_q[i], div_by_zero, dvs_q[i] == 8'h00); end
            stall = $urandom_range(0, 3);
            repeat (stall) begin @(posedge clk); #1; end
            release_op();
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL release[%0d]: in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid); end
        end
    endtask

    task automatic test_stall();
        int lat, acc0;
        issue_op(8'h13, 8'h0A, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL stall_latency: got %0d want 4", lat); end
        acc0 = accepts;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            divisor = 8'($urandom);
            dividend = 8'($urandom);
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_hs[%0d]: out_valid=%b in_ready=%b want 1/0", c, out_valid, in_ready); end
            checks++; if (shamt !== 3'd3 || norm_divisor !== 8'h98 || norm_dividend !== 16'h0050) begin
                errors++; $display("FAIL stall_data[%0d]: shamt=%0d nv=%h nd=%h want 3/98/0050", c, shamt, norm_divisor, norm_dividend); end
        end
        in_valid = 1'b0;
        checks++; if (accepts != acc0) begin errors++; $display("FAIL stall_ignored_valid: accepts=%0d want %0d", accepts, acc0); end
        release_op();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back();
        int lat, acc0;
        logic [7:0] dvd_a, dvd_b;
        dvd_a = 8'($urandom);
        dvd_b = 8'($urandom);
        acc0 = accepts;
        out_ready = 1'b1;
        divisor = 8'h03;
        dividend = dvd_a;
        in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 7) begin errors++; $display("FAIL b2b_latency_a: got %0d want 7", lat); end
        checks++; if (shamt !== 3'd6 || norm_divisor !== 8'hC0 || norm_dividend !== 16'(int'(dvd_a) * 64)) begin
            errors++; $display("FAIL b2b_data_a: shamt=%0d nv=%h nd=%h want 6/c0/%h", shamt, norm_divisor, norm_dividend, 16'(int'(dvd_a) * 64)); end
        divisor = 8'h40;
        dividend = dvd_b;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency_b: got %0d want 2", lat); end
        checks++; if (shamt !== 3'd1 || norm_divisor !== 8'h80 || norm_dividend !== 16'(int'(dvd_b) * 2)) begin
            errors++; $display("FAIL b2b_data_b: shamt=%0d nv=%h nd=%h want 1/80/%h", shamt, norm_divisor, norm_dividend, 16'(int'(dvd_b) * 2)); end
        checks++; if (accepts != acc0 + 2) begin errors++; $display("FAIL b2b_accepts: got %0d want %0d", accepts - acc0, 2); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [7:0] dvd;
        while (!in_ready) begin @(posedge clk); #1; end
        divisor = 8'h01;
        dividend = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_busy: in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        checks++; if (norm_divisor !== 8'h00 || norm_dividend !== 16'h0000 || shamt !== 3'd0) begin
            errors++; $display("FAIL mid_reset_data: nv=%h nd=%h shamt=%0d want 0", norm_divisor, norm_dividend, shamt); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        dvd = 8'($urandom);
        issue_op(8'h20, dvd, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL mid_next_latency: got %0d want 3", lat); end
        checks++; if (shamt !== 3'd2 || norm_divisor !== 8'h80 || norm_dividend !== 16'(int'(dvd) * 4)) begin
            errors++; $display("FAIL mid_next_data: shamt=%0d nv=%h nd=%h want 2/80/%h", shamt, norm_divisor, norm_dividend, 16'(int'(dvd) * 4)); end
        release_op();
    endtask

    initial begin
        test_reset();
        test_normalize();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
